// File: rtl/wb_pkg_hdl.sv
// Shared Wishbone helpers: arbiter state encoding and round-robin pointer arithmetic.
package wb_pkg_hdl;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    TERM  = 2'd2
  } wb_arb_state_t;

  // Index of the master that follows idx in round-robin order.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_core.sv
// Combinational round-robin picker: first set request at or above i_rr_ptr, wrapping.
module wb_rr_arbiter_core #(
  parameter int NUM_MASTERS = 4,
  parameter int PTR_WIDTH   = 2
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [PTR_WIDTH-1:0]   i_rr_ptr,
  output logic [NUM_MASTERS-1:0] o_winner
);

  logic [2*NUM_MASTERS-1:0] w_req2;
  logic [2*NUM_MASTERS-1:0] w_rot2;
  logic [2*NUM_MASTERS-1:0] w_back2;
  logic [NUM_MASTERS-1:0]   w_rot;
  logic [NUM_MASTERS-1:0]   w_pick;

  // Doubling the vector turns the rotate into a plain shift for any master count.
  assign w_req2   = {i_req, i_req};
  assign w_rot2   = w_req2 >> i_rr_ptr;
  assign w_rot    = w_rot2[NUM_MASTERS-1:0];
  assign w_pick   = w_rot & (~w_rot + NUM_MASTERS'(1));
  assign w_back2  = {w_pick, w_pick} << i_rr_ptr;
  assign o_winner = w_back2[2*NUM_MASTERS-1:NUM_MASTERS];

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: one master owns the slave for a whole cyc,
// with a watchdog that terminates unanswered strobes with err.
module wb_arbiter
  import wb_pkg_hdl::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_MASTERS-1:0]                     m_cyc,
  input  logic [NUM_MASTERS-1:0]                     m_stb,
  input  logic [NUM_MASTERS-1:0]                     m_we,
  input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]       m_adr,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]       m_dout,
  input  logic [NUM_MASTERS*(WB_DATA_WIDTH/8)-1:0]   m_sel,
  output logic [WB_DATA_WIDTH-1:0]                   m_din,
  output logic [NUM_MASTERS-1:0]                     m_ack,
  output logic [NUM_MASTERS-1:0]                     m_err,
  output logic [NUM_MASTERS-1:0]                     m_rty,
  output logic                                       s_cyc,
  output logic                                       s_stb,
  output logic                                       s_we,
  output logic [WB_ADDR_WIDTH-1:0]                   s_adr,
  output logic [WB_DATA_WIDTH-1:0]                   s_dout,
  output logic [WB_DATA_WIDTH/8-1:0]                 s_sel,
  input  logic [WB_DATA_WIDTH-1:0]                   s_din,
  input  logic                                       s_ack,
  input  logic                                       s_err,
  input  logic                                       s_rty,
  output logic [NUM_MASTERS-1:0]                     gnt,
  output logic                                       timeout
);

  localparam int SW  = WB_DATA_WIDTH / 8;
  localparam int PW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  wb_arb_state_t          r_state;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [PW-1:0]          r_rr_ptr;
  logic [WDW-1:0]         r_wd_cnt;

  logic [NUM_MASTERS-1:0] w_core_gnt;
  logic [PW-1:0]          w_owner;
  logic [PW-1:0]          w_next_ptr;
  logic                   w_owned;
  logic                   w_term;
  logic                   w_resp;
  logic                   w_owner_cyc;
  logic                   w_wd_fire;

  wb_rr_arbiter_core #(
    .NUM_MASTERS (NUM_MASTERS),
    .PTR_WIDTH   (PW)
  ) u_core (
    .i_req    (m_cyc),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_core_gnt)
  );

  // Outputs are gated by rst so a reset mid-transfer returns nothing to the master.
  assign w_owned     = (r_state == OWNED) && !rst;
  assign w_term      = (r_state == TERM) && !rst;
  assign w_resp      = s_ack | s_err | s_rty;
  assign w_owner_cyc = |(m_cyc & r_gnt);
  assign w_wd_fire   = (r_wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
  assign w_next_ptr  = PW'(rr_next(int'(w_owner), NUM_MASTERS));
  assign gnt         = r_gnt;
  assign timeout     = w_term;
  assign m_din       = rst ? '0 : s_din;

  always_comb begin
    w_owner = '0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dout  = '0;
    s_sel   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_gnt[i]) begin
        w_owner = PW'(i);
        if (w_owned) begin
          s_cyc  = m_cyc[i];
          s_stb  = m_stb[i];
          s_we   = m_we[i];
          s_adr  = m_adr[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
          s_dout = m_dout[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
          s_sel  = m_sel[i*SW +: SW];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
    assign m_ack[gi] = w_owned & r_gnt[gi] & s_ack;
    assign m_rty[gi] = w_owned & r_gnt[gi] & s_rty;
    assign m_err[gi] = r_gnt[gi] & ((w_owned & s_err) | w_term);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_wd_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wd_cnt <= '0;
          if (|m_cyc) begin
            r_gnt   <= w_core_gnt;
            r_state <= OWNED;
          end
        end
        OWNED: begin
          if (!w_owner_cyc) begin
            r_gnt    <= '0;
            r_rr_ptr <= w_next_ptr;
            r_wd_cnt <= '0;
            r_state  <= IDLE;
          end else if ((TIMEOUT_CYCLES != 0) && s_stb && !w_resp) begin
            if (w_wd_fire) begin
              r_wd_cnt <= '0;
              r_state  <= TERM;
            end else begin
              r_wd_cnt <= r_wd_cnt + WDW'(1);
            end
          end else begin
            r_wd_cnt <= '0;
          end
        end
        TERM: begin
          r_gnt    <= '0;
          r_rr_ptr <= w_next_ptr;
          r_wd_cnt <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized masters/slave
// compared every cycle against an ownership-level reference model.
module tb_wb_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dout;
  logic [N*SW-1:0] m_sel;
  logic [DW-1:0]   m_din;
  logic [N-1:0]    m_ack, m_err, m_rty, gnt;
  logic            s_cyc, s_stb, s_we, timeout;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dout, s_din;
  logic [SW-1:0]   s_sel;
  logic            s_ack, s_err, s_rty;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus, whether it is being terminated,
  // where the next search starts and how many strobes went unanswered.
  int md_owner = -1;
  bit md_term  = 1'b0;
  int md_ptr   = 0;
  int md_silent = 0;

  logic [N-1:0]  x_gnt, x_ack, x_err, x_rty;
  logic          x_cyc, x_stb, x_we, x_to;
  logic [AW-1:0] x_adr;
  logic [DW-1:0] x_dout, x_din;
  logic [SW-1:0] x_sel;

  wb_arbiter #(
    .NUM_MASTERS    (N),
    .WB_ADDR_WIDTH  (AW),
    .WB_DATA_WIDTH  (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_adr   (m_adr),
    .m_dout  (m_dout),
    .m_sel   (m_sel),
    .m_din   (m_din),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .m_rty   (m_rty),
    .s_cyc   (s_cyc),
    .s_stb   (s_stb),
    .s_we    (s_we),
    .s_adr   (s_adr),
    .s_dout  (s_dout),
    .s_sel   (s_sel),
    .s_din   (s_din),
    .s_ack   (s_ack),
    .s_err   (s_err),
    .s_rty   (s_rty),
    .gnt     (gnt),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got still running expected finished");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all outputs with the model for the current inputs, then advance one clock.
  task automatic step();
    bit owned;
    bit any_resp;
    int found;
    #1;
    owned  = (md_owner >= 0) && !md_term && !rst;
    x_gnt  = (md_owner >= 0) ? (N'(1) << md_owner) : '0;
    x_cyc  = 1'b0; x_stb = 1'b0; x_we = 1'b0;
    x_adr  = '0; x_dout = '0; x_sel = '0;
    x_ack  = '0; x_err = '0; x_rty = '0;
    if (owned) begin
      x_cyc  = m_cyc[md_owner];
      x_stb  = m_stb[md_owner];
      x_we   = m_we[md_owner];
      x_adr  = m_adr[md_owner*AW +: AW];
      x_dout = m_dout[md_owner*DW +: DW];
      x_sel  = m_sel[md_owner*SW +: SW];
      if (s_ack) x_ack = x_gnt;
      if (s_rty) x_rty = x_gnt;
    end
    if ((owned && s_err) || (md_term && !rst)) x_err = x_gnt;
    x_to  = md_term && !rst;
    x_din = rst ? '0 : s_din;

    check_eq("gnt",     64'(gnt),     64'(x_gnt));
    check_eq("s_cyc",   64'(s_cyc),   64'(x_cyc));
    check_eq("s_stb",   64'(s_stb),   64'(x_stb));
    check_eq("s_we",    64'(s_we),    64'(x_we));
    check_eq("s_adr",   64'(s_adr),   64'(x_adr));
    check_eq("s_dout",  64'(s_dout),  64'(x_dout));
    check_eq("s_sel",   64'(s_sel),   64'(x_sel));
    check_eq("m_din",   64'(m_din),   64'(x_din));
    check_eq("m_ack",   64'(m_ack),   64'(x_ack));
    check_eq("m_err",   64'(m_err),   64'(x_err));
    check_eq("m_rty",   64'(m_rty),   64'(x_rty));
    check_eq("timeout", 64'(timeout), 64'(x_to));

    any_resp = s_ack | s_err | s_rty;
    if (rst) begin
      md_owner = -1; md_term = 1'b0; md_ptr = 0; md_silent = 0;
    end else if (md_term) begin
      md_ptr = (md_owner + 1) % N; md_owner = -1; md_term = 1'b0; md_silent = 0;
    end else if (md_owner < 0) begin
      found = -1;
      for (int k = 0; k < N; k++)
        if (found < 0 && m_cyc[(md_ptr + k) % N]) found = (md_ptr + k) % N;
      md_owner = found;
      md_silent = 0;
    end else if (!m_cyc[md_owner]) begin
      md_ptr = (md_owner + 1) % N; md_owner = -1; md_silent = 0;
    end else if (m_stb[md_owner] && !any_resp) begin
      md_silent++;
      if (md_silent == TO) begin
        md_term = 1'b1;
        md_silent = 0;
      end
    end else begin
      md_silent = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dout = '0; m_sel = '0;
    s_din = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  bit act[N];
  int rem[N];
  int mute;
  int to_at;
  int r;

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    step();
    rst = 1'b0;
    step();

    // Single master 0 write, slave acks after two wait states.
    m_cyc = 4'b0001; m_stb = 4'b0001; m_we = 4'b0001;
    m_adr[AW-1:0] = 32'h10; m_dout[DW-1:0] = 16'hBEEF; m_sel[SW-1:0] = 2'b11;
    step();
    #1;
    check_eq("d1_gnt", 64'(gnt), 64'h1);
    check_eq("d1_sadr", 64'(s_adr), 64'h10);
    step(); step();
    s_ack = 1'b1;
    #1;
    check_eq("d1_ack", 64'(m_ack), 64'h1);
    step();
    s_ack = 1'b0;
    clear_inputs();
    step(); step();
    $display("txn d1: master0 write 0xBEEF @0x10 done");

    // Masters 0 and 2 together from rr_ptr=0.
    rst = 1'b1; step(); rst = 1'b0;
    m_cyc = 4'b0101; m_stb = 4'b0101;
    step();
    #1 check_eq("d2_first", 64'(gnt), 64'h1);
    s_ack = 1'b1; step(); s_ack = 1'b0;
    m_cyc = 4'b0100; m_stb = 4'b0100;
    step();
    #1 check_eq("d2_idle", 64'(gnt), 64'h0);
    step();
    #1 check_eq("d2_second", 64'(gnt), 64'h4);
    m_cyc = '0; m_stb = '0;
    step();
    m_cyc = 4'b1001; m_stb = 4'b1001;
    step();
    #1 check_eq("d2_ptr3", 64'(gnt), 64'h8);
    m_cyc = '0; m_stb = '0;
    step(); step();
    $display("txn d2: masters 0 then 2, next winner 3");

    // Master 1 holds the bus over four acked strobes while master 3 waits.
    m_cyc = 4'b1010; m_stb = 4'b1010;
    step();
    s_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 check_eq("d3_hold", 64'(gnt), 64'h2);
      step();
    end
    s_ack = 1'b0;
    m_cyc = 4'b1000; m_stb = 4'b1000;
    step(); step();
    #1 check_eq("d3_next", 64'(gnt), 64'h8);
    m_cyc = '0; m_stb = '0;
    step(); step();
    $display("txn d3: master1 burst of 4, then master3");

    // Silent slave: watchdog must terminate after TO unanswered strobes.
    m_cyc = 4'b0001; m_stb = 4'b0001;
    step();
    to_at = -1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (timeout && to_at < 0) begin
        to_at = c;
        check_eq("d4_err", 64'(m_err), 64'h1);
        check_eq("d4_scyc", 64'(s_cyc), 64'h0);
      end
      step();
    end
    check_eq("d4_at", 64'(to_at), 64'd8);
    m_cyc = '0; m_stb = '0;
    step(); step();
    $display("txn d4: watchdog termination at owned cycle %0d", to_at);

    // Reset in the middle of a read, then a fresh grant.
    m_cyc = 4'b0100; m_stb = 4'b0100;
    step(); step();
    rst = 1'b1; s_ack = 1'b1;
    #1 check_eq("d5_noack", 64'(m_ack), 64'h0);
    step();
    rst = 1'b0; s_ack = 1'b0;
    #1;
    check_eq("d5_gnt", 64'(gnt), 64'h0);
    check_eq("d5_scyc", 64'(s_cyc), 64'h0);
    step();
    #1 check_eq("d5_regnt", 64'(gnt), 64'h4);

    // Read terminated by slave err carries data through.
    s_din = 16'h1234; s_err = 1'b1;
    #1;
    check_eq("d6_din", 64'(m_din), 64'h1234);
    check_eq("d6_err", 64'(m_err), 64'h4);
    check_eq("d6_ack", 64'(m_ack), 64'h0);
    check_eq("d6_to", 64'(timeout), 64'h0);
    step();
    clear_inputs();
    step(); step();
    $display("txn d5/d6: reset abort, regrant, read err with data 0x1234");

    // Randomized masters and slave.
    mute = 0;
    for (int i = 0; i < N; i++) begin act[i] = 1'b0; rem[i] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(0, 3) == 0) begin
          act[i] = 1'b1;
          rem[i] = $urandom_range(1, 4);
        end
        m_cyc[i] = act[i];
        m_stb[i] = act[i] && ($urandom_range(0, 7) != 0);
        m_we[i]  = 1'($urandom);
        m_adr[i*AW +: AW]  = 32'($urandom);
        m_dout[i*DW +: DW] = 16'($urandom);
        m_sel[i*SW +: SW]  = 2'($urandom);
      end
      s_din = 16'($urandom);
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      if (mute > 0) begin
        mute--;
      end else if ($urandom_range(0, 39) == 0) begin
        mute = 12;
      end else begin
        r = $urandom_range(0, 9);
        if (r < 3) s_ack = 1'b1;
        else if (r == 3) s_err = 1'b1;
        else if (r == 4) s_rty = 1'b1;
      end
      step();
      for (int i = 0; i < N; i++) begin
        if (act[i] && (x_ack[i] | x_err[i] | x_rty[i])) begin
          rem[i]--;
          if (rem[i] == 0) begin
            act[i] = 1'b0;
            $display("txn random: master%0d bus cycle complete at %0t", i, $time);
          end
        end
      end
    end
    rst = 1'b0;
    clear_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Round-robin arbiter sharing one Wishbone slave port among NUM_MASTERS initiators.
- Sits between several wb initiators (DUT masters or driver BFMs in INITIATOR mode) and a single responder.
- Holds a grant for a whole bus cycle (cyc high), so block transfers are never split.
- A per-transfer watchdog terminates hung transfers with err.

Parameters:
- NUM_MASTERS, 4, number of requesting initiators (2..8).
- WB_ADDR_WIDTH, 32, address width.
- WB_DATA_WIDTH, 16, data width; sel width is WB_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, stb-without-response cycles before forced err; 0 disables the watchdog.

Ports:
- clk  in  1  bus clock.
- rst  in  1  synchronous, active-high reset.
- m_cyc  in  NUM_MASTERS  per-master cycle request.
- m_stb  in  NUM_MASTERS  per-master strobe.
- m_we  in  NUM_MASTERS  per-master write enable.
- m_adr  in  NUM_MASTERS*WB_ADDR_WIDTH  packed addresses; master i at slice i.
- m_dout  in  NUM_MASTERS*WB_DATA_WIDTH  packed write data.
- m_sel  in  NUM_MASTERS*(WB_DATA_WIDTH/8)  packed byte selects.
- m_din  out  WB_DATA_WIDTH  read data, broadcast to all masters.
- m_ack  out  NUM_MASTERS  per-master ack.
- m_err  out  NUM_MASTERS  per-master err.
- m_rty  out  NUM_MASTERS  per-master rty.
- s_cyc  out  1  slave cycle.
- s_stb  out  1  slave strobe.
- s_we  out  1  slave write enable.
- s_adr  out  WB_ADDR_WIDTH  slave address.
- s_dout  out  WB_DATA_WIDTH  slave write data.
- s_sel  out  WB_DATA_WIDTH/8  slave byte select.
- s_din  in  WB_DATA_WIDTH  slave read data.
- s_ack  in  1  slave ack.
- s_err  in  1  slave err.
- s_rty  in  1  slave rty.
- gnt  out  NUM_MASTERS  registered one-hot grant.
- timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, gnt=0, rr_ptr=0, wd_cnt=0, timeout=0.
  - All s_* outputs and m_ack/m_err/m_rty are 0; s_adr, s_dout and m_din are 0.
  - Reset mid-transfer aborts immediately, with no response to the master.
- FSM states: IDLE, OWNED, TERM.
- IDLE:
  - If any m_cyc is set, pick the first requester scanning from rr_ptr upward, wrapping modulo NUM_MASTERS.
  - Register gnt=onehot(winner) and go to OWNED.
  - Arbitration latency: exactly 1 clk from the m_cyc rise to gnt.
  - s_cyc and s_stb are 0 while in IDLE.
- OWNED:
  - s_cyc/s_stb/s_we/s_adr/s_dout/s_sel are combinationally muxed from the granted master.
  - s_ack/s_err/s_rty are routed only to the granted bit of m_ack/m_err/m_rty; other masters see 0.
  - m_din = s_din always.
  - Grant is held while the granted m_cyc=1; other requests are ignored.
  - When the granted m_cyc=0 at a posedge: gnt=0, rr_ptr=winner+1 (wrap), go to IDLE.
  - Minimum 1 idle cycle between ownerships (no back-to-back handover).
- Watchdog (TIMEOUT_CYCLES>0, OWNED only):
  - wd_cnt increments each cycle s_stb=1 and s_ack|s_err|s_rty=0.
  - wd_cnt clears on any response or when stb=0.
  - When wd_cnt reaches TIMEOUT_CYCLES-1 with no response, go to TERM.
- TERM (exactly 1 cycle):
  - s_cyc=s_stb=0; m_err[winner]=1; timeout=1; wd_cnt=0.
  - Then gnt=0, rr_ptr=winner+1, state=IDLE.
  - A slave response arriving during TERM is dropped.
- Simultaneous events:
  - A response on the same cycle the watchdog would fire takes precedence; no timeout.
  - A new request in the cycle of release is served on the following IDLE evaluation.
- Single requester: it is re-granted after 1 idle cycle on every cycle request.

Decomposition:
- Shared package wb_pkg_hdl (existing): add localparam-free typedef wb_arb_state_t {IDLE, OWNED, TERM}.
- One sub-module: wb_rr_arbiter_core.
  - Inputs: req vector, rr_ptr. Output: one-hot winner.
  - Purely combinational; rotate, priority-encode, rotate back.
  - Reusable and unit-testable on its own.

Test Plan:
- Single master 0 write: adr=0x10, dout=0xBEEF, slave acks after 2 cycles -> gnt=0001 one clk after cyc; s_adr=0x10; m_ack[0] one pulse; others 0.
- Masters 0 and 2 assert cyc on the same cycle, rr_ptr=0 -> master 0 granted first; on release, 1 idle cycle, then gnt=0100; next arbitration rr_ptr=3.
- Master 1 holds cyc over 4 acked stbs while master 3 requests -> gnt stays 0010 for all 4; master 3 granted only after master 1 drops cyc.
- Slave never responds, TIMEOUT_CYCLES=8 -> after 8 stb cycles, m_err[granted]=1 and timeout=1 for 1 cycle; s_cyc=0 that cycle; then IDLE.
- rst=1 in OWNED mid-read -> next cycle gnt=0, s_cyc=0, m_ack=0, rr_ptr=0; a fresh request gets granted normally.
- Read with s_din=0x1234 and s_err=1 -> m_din=0x1234, m_err[granted]=1, m_ack=0, watchdog idle.
